// File: rtl/a2d_spi_resp_if.sv
// SPI link between the A2D stand-in and its master: select, clock, command in, data out.
interface a2d_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_resp.sv
// ADC128S-style SPI responder: returns the channel chosen by the previous command,
// sourcing conversion values from a parallel bus. All SPI pins are oversampled on clk.
module a2d_spi_resp #(
  parameter int DATA_W   = 12,
  parameter int NUM_CH   = 8,
  parameter int RST_CHNL = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  a2d_spi_resp_if.slave            spi,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [2:0]               chnl_nxt,
  output logic [15:0]              last_cmd,
  output logic                     xfer_done,
  output logic                     frame_err,
  output logic [7:0]               xfer_cnt
);

  typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT} state_t;

  localparam logic [2:0] RST_CH = RST_CHNL[2:0];

  logic [DATA_W-1:0] ch_arr [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_arr[gi] = ch_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  state_t      state_q, state_d;
  logic [2:0]  ss_sync_q, ss_sync_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] tx_shft_q, tx_shft_d;
  logic [15:0] rx_shft_q, rx_shft_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  chnl_nxt_q, chnl_nxt_d;
  logic [15:0] last_cmd_q, last_cmd_d;
  logic        xfer_done_q, xfer_done_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  xfer_cnt_q, xfer_cnt_d;

  logic ss_rise, ss_fall, sclk_rise, sclk_fall;

  // Bit 1 of each chain is the synchronized pin, bit 2 its one-clk-old copy for edges.
  assign ss_rise   =  ss_sync_q[1]   & ~ss_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1]   &  ss_sync_q[2];
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];

  always_comb begin
    state_d     = state_q;
    ss_sync_d   = {ss_sync_q[1:0], spi.SS_n};
    sclk_sync_d = {sclk_sync_q[1:0], spi.SCLK};
    mosi_sync_d = {mosi_sync_q[0], spi.MOSI};
    flush_cnt_d = flush_cnt_q;
    tx_shft_d   = tx_shft_q;
    rx_shft_d   = rx_shft_q;
    bit_cnt_d   = bit_cnt_q;
    chnl_nxt_d  = chnl_nxt_q;
    last_cmd_d  = last_cmd_q;
    xfer_done_d = 1'b0;
    frame_err_d = 1'b0;
    xfer_cnt_d  = xfer_cnt_q;

    case (state_q)
      WAIT_HI: begin
        // The SS_n chain resets high, so only trust it once the pin has reached bit 1.
        if (flush_cnt_q != 2'd2) begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end else if (ss_sync_q[1]) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (ss_fall) begin
          tx_shft_d = 16'(ch_arr[chnl_nxt_q]);
          bit_cnt_d = 5'd0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (ss_rise) begin
          if (bit_cnt_q == 5'd16) begin
            last_cmd_d  = rx_shft_q;
            chnl_nxt_d  = rx_shft_q[13:11];
            xfer_cnt_d  = xfer_cnt_q + 8'd1;
            xfer_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (sclk_rise) begin
          rx_shft_d = {rx_shft_q[14:0], mosi_sync_q[1]};
          if (bit_cnt_q != 5'd17) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (sclk_fall && (bit_cnt_q != 5'd0)) begin
          tx_shft_d = {tx_shft_q[14:0], 1'b0};
        end
      end

      default: state_d = WAIT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_HI;
      ss_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
      flush_cnt_q <= 2'd0;
      tx_shft_q   <= 16'h0000;
      rx_shft_q   <= 16'h0000;
      bit_cnt_q   <= 5'd0;
      chnl_nxt_q  <= RST_CH;
      last_cmd_q  <= 16'h0000;
      xfer_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      xfer_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      flush_cnt_q <= flush_cnt_d;
      tx_shft_q   <= tx_shft_d;
      rx_shft_q   <= rx_shft_d;
      bit_cnt_q   <= bit_cnt_d;
      chnl_nxt_q  <= chnl_nxt_d;
      last_cmd_q  <= last_cmd_d;
      xfer_done_q <= xfer_done_d;
      frame_err_q <= frame_err_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign spi.MISO  = (state_q == SHIFT) & tx_shft_q[15];
  assign chnl_nxt  = chnl_nxt_q;
  assign last_cmd  = last_cmd_q;
  assign xfer_done = xfer_done_q;
  assign frame_err = frame_err_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Randomized bench for a2d_spi_resp: an SPI master task drives frames and a per-frame
// reference model (channel table, selected channel, counters) predicts every result.
module tb_a2d_spi_resp;
  localparam int DW   = 12;
  localparam int NC   = 8;
  localparam int HALF = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NC*DW-1:0] ch_data;
  logic [2:0]     chnl_nxt;
  logic [15:0]    last_cmd;
  logic           xfer_done;
  logic           frame_err;
  logic [7:0]     xfer_cnt;

  a2d_spi_resp_if spi_if();

  a2d_spi_resp #(.DATA_W(DW), .NUM_CH(NC), .RST_CHNL(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi      (spi_if),
    .ch_data  (ch_data),
    .chnl_nxt (chnl_nxt),
    .last_cmd (last_cmd),
    .xfer_done(xfer_done),
    .frame_err(frame_err),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int frame_no  = 0;

  // Reference model state
  logic [11:0] m_ch [NC];
  logic [2:0]  m_nxt;
  logic [7:0]  m_cnt;
  logic [15:0] m_last;

  // Counting high cycles (not edges) also catches a pulse that lasts too long.
  always @(negedge clk) begin
    if (xfer_done === 1'b1) done_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    m_ch[k] = v;
    ch_data[k*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_n(2);
    rst = 1'b0;
    m_nxt  = 3'd0;
    m_cnt  = 8'd0;
    m_last = 16'h0000;
  endtask

  task automatic run_frame(input logic [15:0] cmd, input int nbits, input int chg_bit,
                           input int chg_ch, input logic [11:0] chg_val, input int rst_bit);
    logic [31:0] rxw;
    logic [31:0] expw;
    logic [15:0] word;
    int d0, e0;
    bit aborted;
    word    = {4'b0000, m_ch[m_nxt]};
    rxw     = 32'h0;
    d0      = done_seen;
    e0      = err_seen;
    aborted = 1'b0;
    frame_no++;
    spi_if.MOSI = cmd[15];
    spi_if.SS_n = 1'b0;
    clk_n(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_if.SCLK = 1'b1;
      rxw = {rxw[30:0], spi_if.MISO};
      clk_n(HALF);
      if (i == chg_bit) set_ch(chg_ch, chg_val);
      spi_if.SCLK = 1'b0;
      if (i == rst_bit) begin
        aborted = 1'b1;
        break;
      end
      spi_if.MOSI = (i + 1 < 16) ? cmd[14-i] : 1'b0;
      clk_n(HALF);
    end
    if (aborted) begin
      clk_n(1);
      do_reset();
      clk_n(4);
      chk("rst_miso", {31'h0, spi_if.MISO}, 32'h0);
      chk("rst_nxt", {29'h0, chnl_nxt}, 32'h0);
      chk("rst_cnt", {24'h0, xfer_cnt}, 32'h0);
      chk("rst_last", {16'h0, last_cmd}, 32'h0);
      spi_if.SS_n = 1'b1;
      spi_if.MOSI = 1'b0;
      clk_n(6);
      chk("rst_done", done_seen - d0, 32'h0);
      chk("rst_err", err_seen - e0, 32'h0);
      $display("frame %0d cmd=%04h bits=%0d aborted by reset", frame_no, cmd, rst_bit + 1);
      return;
    end
    spi_if.SS_n = 1'b1;
    spi_if.MOSI = 1'b0;
    clk_n(6);
    expw = {word, 16'h0000} >> (32 - nbits);
    if (nbits == 16) begin
      m_last = cmd;
      m_nxt  = cmd[13:11];
      m_cnt  = m_cnt + 8'd1;
    end
    chk("miso", rxw, expw);
    chk("done", done_seen - d0, {31'h0, nbits == 16});
    chk("err", err_seen - e0, {31'h0, nbits != 16});
    chk("nxt", {29'h0, chnl_nxt}, {29'h0, m_nxt});
    chk("last", {16'h0, last_cmd}, {16'h0, m_last});
    chk("cnt", {24'h0, xfer_cnt}, {24'h0, m_cnt});
    $display("frame %0d cmd=%04h bits=%0d miso=%0h exp=%0h nxt=%0d cnt=%0d",
             frame_no, cmd, nbits, rxw, expw, chnl_nxt, xfer_cnt);
  endtask

  initial begin
    logic [31:0] rxw;
    int d0, e0;
    spi_if.SS_n = 1'b0;
    spi_if.SCLK = 1'b0;
    spi_if.MOSI = 1'b0;
    ch_data = '0;
    for (int k = 0; k < NC; k++) set_ch(k, 12'($urandom));
    set_ch(0, 12'hFFF);

    // Reset held with SS_n low: nothing may shift until SS_n goes high then low.
    clk_n(1);
    do_reset();
    clk_n(1);
    chk("reset_miso", {31'h0, spi_if.MISO}, 32'h0);
    chk("reset_nxt", {29'h0, chnl_nxt}, 32'h0);
    chk("reset_cnt", {24'h0, xfer_cnt}, 32'h0);
    chk("reset_last", {16'h0, last_cmd}, 32'h0);
    d0 = done_seen;
    e0 = err_seen;
    rxw = 32'h0;
    spi_if.MOSI = 1'b1;
    for (int i = 0; i < 16; i++) begin
      spi_if.SCLK = 1'b1;
      rxw = {rxw[30:0], spi_if.MISO};
      clk_n(HALF);
      spi_if.SCLK = 1'b0;
      clk_n(HALF);
    end
    spi_if.SS_n = 1'b1;
    spi_if.MOSI = 1'b0;
    clk_n(6);
    chk("waithi_miso", rxw, 32'h0);
    chk("waithi_done", done_seen - d0, 32'h0);
    chk("waithi_err", err_seen - e0, 32'h0);
    chk("waithi_nxt", {29'h0, chnl_nxt}, 32'h0);
    $display("headless frame with SS_n low after reset: miso=%0h", rxw);

    // Channel sequence
    set_ch(0, 12'h123);
    set_ch(1, 12'h456);
    run_frame(16'h0800, 16, -1, 0, 12'h0, -1);
    run_frame(16'h0000, 16, -1, 0, 12'h0, -1);

    // Short and long frames
    run_frame(16'($urandom), 9, -1, 0, 12'h0, -1);
    run_frame(16'($urandom), 17, -1, 0, 12'h0, -1);

    // ch_data is captured at SS_n fall only
    set_ch(5, 12'hFFF);
    run_frame(16'h2800, 16, -1, 0, 12'h0, -1);
    run_frame(16'h2800, 16, 4, 5, 12'h000, -1);
    run_frame(16'h0000, 16, -1, 0, 12'h0, -1);

    // Mid-frame reset after 8 SCLK cycles
    run_frame(16'($urandom), 16, -1, 0, 12'h0, 7);

    // 256 valid frames from a fresh reset: counter wraps to 0; first frame returns ch0
    d0 = done_seen;
    for (int n = 0; n < 256; n++) begin
      if ($urandom_range(0, 3) == 0) set_ch(int'($urandom_range(0, NC-1)), 12'($urandom));
      run_frame(16'($urandom), 16, -1, 0, 12'h0, -1);
    end
    chk("wrap_cnt", {24'h0, xfer_cnt}, 32'h0);
    chk("wrap_done", done_seen - d0, 32'd256);

    // Mixed random frame lengths
    for (int n = 0; n < 20; n++) begin
      int nb;
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 16;
      if ($urandom_range(0, 1) == 0) set_ch(int'($urandom_range(0, NC-1)), 12'($urandom));
      run_frame(16'($urandom), nb, -1, 0, 12'h0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/a2d_spi_resp.md
Name: a2d_spi_resp

Overview:
Synthesizable SPI responder that emulates the ADC128S-style 8-channel, 12-bit A2D on the far end of the A2D SPI link. It receives the 16-bit channel command from the SPI master and returns conversion data for the channel selected in the previous transaction. Channel values come in on a parallel bus, driven by a bench or stimulus logic. It serves as the on-chip/FPGA stand-in for the A2D when exercising the load-cell, steering-pot and battery path.

Parameters:
DATA_W, 12, conversion width per channel; returned data is zero-padded to 16 bits.
NUM_CH, 8, number of channels; the select field is 3 bits.
RST_CHNL, 0, channel returned by the first transaction after reset.

Ports:
clk  input  1  system clock; all logic rising-edge.
rst  input  1  synchronous, active-high reset.
SS_n  input  1  SPI select, active low; asynchronous to clk.
SCLK  input  1  SPI clock, mode 0 (idle low); at most clk/8.
MOSI  input  1  command from master; sampled on SCLK rise.
MISO  output  1  data to master; changes on SCLK fall.
ch_data  input  NUM_CH*DATA_W  channel values; channel k occupies [k*DATA_W +: DATA_W].
chnl_nxt  output  3  channel to be returned by the next transaction.
last_cmd  output  16  last complete command word received.
xfer_done  output  1  one-clk pulse after a valid 16-bit frame.
frame_err  output  1  one-clk pulse after a frame that is not exactly 16 bits.
xfer_cnt  output  8  count of valid frames; wraps at 256.

Behaviour:
- Interface decision: one clock (clk); synchronous, active-high reset (rst).
- Synchronizers: SS_n, SCLK and MOSI each pass through 2 flops, plus 1 flop for edge detect.
  - Synchronizer reset values: SS_n=1, SCLK=0, MOSI=0.
  - Edge-detect latency from a pin change: 3 clk.
- Reset values: MISO=0, chnl_nxt=RST_CHNL, last_cmd=0, xfer_done=0, frame_err=0, xfer_cnt=0, state=WAIT_HI.
- State WAIT_HI: entered after reset. Ignores all activity until synced SS_n is seen high, then moves to IDLE. This prevents starting mid-frame when rst releases with SS_n low.
- State IDLE: MISO=0.
  - On SS_n fall: load tx_shft = {(16-DATA_W) zeros, ch_data[chnl_nxt]}; clear bit_cnt; go to SHIFT.
  - ch_data is sampled only at this instant; changes during the frame do not affect the returned word.
- State SHIFT: MISO = tx_shft[15], so the MSB is valid within 3 clk of the SS_n fall.
  - SCLK rise: rx_shft <= {rx_shft[14:0], MOSI_sync}; bit_cnt increments, saturating at 17 (5-bit counter).
  - SCLK fall: if bit_cnt != 0, shift tx_shft left and fill with 0. A fall before any rise is ignored.
  - After 16 bits MISO reads 0.
  - SS_n rise with bit_cnt==16: last_cmd <= rx_shft; chnl_nxt <= rx_shft[13:11]; xfer_cnt++; xfer_done pulses 1 clk; go to IDLE.
  - SS_n rise with bit_cnt!=16 (short, or more than 16 rises): frame_err pulses 1 clk; chnl_nxt, last_cmd and xfer_cnt are unchanged; go to IDLE.
- Simultaneous edges:
  - An SS_n edge and an SCLK edge detected in the same clk: the SS_n edge wins and the SCLK edge is dropped.
  - SCLK rise and fall cannot occur in the same clk, given the clk/8 limit.
- Command bits other than [13:11] are stored in last_cmd but have no effect.
- rst mid-frame: immediate return to reset values and WAIT_HI. The partial frame produces no xfer_done and no frame_err.

Test Plan:
1. Reset: rst high 2 clk with SS_n low -> MISO=0, chnl_nxt=0, xfer_cnt=0. Then an SS_n low->high->low sequence is required before shifting begins.
2. Channel sequence: ch0=0x123, ch1=0x456.
   - Frame 1, MOSI=0x0800 -> MISO word=0x0123, chnl_nxt=1, last_cmd=0x0800, xfer_done single pulse, xfer_cnt=1.
   - Frame 2, MOSI=0x0000 -> MISO word=0x0456, chnl_nxt=0.
3. Short frame: 9 SCLK cycles then SS_n high -> frame_err one pulse, xfer_done=0, chnl_nxt and xfer_cnt unchanged.
   - Long frame (17 SCLK cycles) -> frame_err as well.
4. Data stability: ch5=0xFFF selected (chnl_nxt=5); change ch5 to 0x000 after bit 4 of the next frame -> returned word=0x0FFF. The following frame returns 0x0000.
5. Wrap: 256 valid frames -> xfer_cnt=0 and exactly 256 xfer_done pulses.
6. Mid-frame reset: rst asserted after 8 SCLK cycles -> no xfer_done or frame_err, chnl_nxt=0, MISO=0. The next full frame returns ch0.
